// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and helpers for the branch predictor: counter container, reset value
// and saturating update. Used by both the gshare and the bimodal build.
package BranchPredictorTypes;

    localparam int unsigned MAX_CTR_W = 4;
    localparam int unsigned DEF_IDX_W = 8;

    typedef logic [DEF_IDX_W-1:0] pht_idx_t;
    typedef logic [MAX_CTR_W-1:0] ctr_t;

    // Weakly not-taken: one below the taken threshold.
    function automatic ctr_t ctr_reset(input int unsigned width);
        return ctr_t'((32'd1 << (width - 1)) - 32'd1);
    endfunction

    localparam ctr_t CTR_RESET_DEFAULT = ctr_reset(2);

    function automatic ctr_t sat_next(input ctr_t cur, input logic inc, input int unsigned width);
        ctr_t maxv;
        maxv = ctr_t'((32'd1 << width) - 32'd1);
        if (inc) begin
            return (cur == maxv) ? cur : cur + ctr_t'(1);
        end
        return (cur == '0) ? cur : cur - ctr_t'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_pht.sv
// Pattern history table: saturating counters with one combinational read port and one
// read-modify-write update port.
module pattern_history_table
    import BranchPredictorTypes::*;
#(
    parameter int unsigned ENTRY_NUM     = 256,
    parameter int unsigned COUNTER_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(ENTRY_NUM)-1:0] rd_idx_i,
    output logic [COUNTER_WIDTH-1:0]     rd_ctr_o,
    input  logic                         wr_en_i,
    input  logic [$clog2(ENTRY_NUM)-1:0] wr_idx_i,
    input  logic                         wr_inc_i
);

    localparam logic [COUNTER_WIDTH-1:0] RST_VAL = COUNTER_WIDTH'(ctr_reset(COUNTER_WIDTH));

    logic [COUNTER_WIDTH-1:0] pht_q [ENTRY_NUM];
    logic [COUNTER_WIDTH-1:0] wr_ctr_d;

    always_comb begin
        wr_ctr_d = COUNTER_WIDTH'(sat_next(ctr_t'(pht_q[wr_idx_i]), wr_inc_i, COUNTER_WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                pht_q[i] <= RST_VAL;
            end
        end else if (wr_en_i) begin
            pht_q[wr_idx_i] <= wr_ctr_d;
        end
    end

    // No bypass: a same-cycle read sees the pre-update counter.
    assign rd_ctr_o = pht_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor_gshare.sv
// Dynamic branch predictor top: index hash, GHR and misprediction statistics.
// Define BRANCH_PREDICTOR_GSHARE_EN for gshare hashing; otherwise bimodal (ghr tied to 0).
module branch_predictor_gshare
    import BranchPredictorTypes::*;
#(
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned ENTRY_NUM     = 256,
    parameter int unsigned GHR_WIDTH     = 8,
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter int unsigned STAT_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PC_WIDTH-1:0]          fetchPc,
    output logic                         predictTaken,
    output logic [$clog2(ENTRY_NUM)-1:0] predictIndex,
    input  logic                         exIsBranch,
    input  logic                         exBranchTaken,
    input  logic                         exPredictedTaken,
    input  logic [$clog2(ENTRY_NUM)-1:0] exIndex,
    output logic [STAT_WIDTH-1:0]        mispredictCount,
    output logic [GHR_WIDTH-1:0]         ghr
);

    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);

    logic [COUNTER_WIDTH-1:0] rd_ctr;
    logic [STAT_WIDTH-1:0]    miss_q, miss_d;

    logic unused_pc_lo;
    assign unused_pc_lo = ^fetchPc[1:0];
    if (PC_WIDTH > IDX_W + 2) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^fetchPc[PC_WIDTH-1:IDX_W+2];
    end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d, ghr_shift;

    if (GHR_WIDTH == 1) begin : g_ghr1
        assign ghr_shift = exBranchTaken;
    end else begin : g_ghrn
        assign ghr_shift = {ghr_q[GHR_WIDTH-2:0], exBranchTaken};
    end

    always_comb begin
        ghr_d = ghr_q;
        if (exIsBranch) begin
            ghr_d = ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign predictIndex = fetchPc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign ghr          = ghr_q;
`else
    assign predictIndex = fetchPc[IDX_W+1:2];
    assign ghr          = '0;
`endif

    pattern_history_table #(
        .ENTRY_NUM    (ENTRY_NUM),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_pht (
        .clk     (clk),
        .rst_n   (rst),
        .rd_idx_i(predictIndex),
        .rd_ctr_o(rd_ctr),
        .wr_en_i (exIsBranch),
        .wr_idx_i(exIndex),
        .wr_inc_i(exBranchTaken)
    );

    assign predictTaken = rd_ctr[COUNTER_WIDTH-1];

    always_comb begin
        miss_d = miss_q;
        if (exIsBranch && (exBranchTaken != exPredictedTaken)) begin
            miss_d = miss_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign mispredictCount = miss_q;

endmodule
